// File: rtl/fpmult_rr_arbiter.sv
// -----------------------------------------------------------------------------
// fpmult_rr_arbiter
//
// Shares one fixed-latency pipelined FP32 multiplier among NREQ requesters.
// A round-robin arbiter grants at most one request per cycle, the granted
// operands are registered onto the multiplier inputs, and a tag pipeline that
// runs in lock-step with the multiplier remembers which requester issued each
// operation so the product can be steered back as a one-hot response strobe.
// No arithmetic happens here; operands and products pass through unmodified.
//
// Build option:
//   FPMULT_ARB_FLAGS_EN  defined   -> rsp_flags registered from mul_flags
//                        undefined -> rsp_flags tied to zero, mul_flags unused
//
// Ports:
//   clk         in   1        rising-edge clock
//   rst         in   1        synchronous, active-high reset
//   req_valid   in   NREQ     per-requester operation request
//   req_a       in   NREQ*32  operand A, requester i at [32i+31:32i]
//   req_b       in   NREQ*32  operand B, same packing as req_a
//   req_ready   out  NREQ     one-hot grant (combinational)
//   issue_hold  in   1        suppresses new grants, in-flight ops drain
//   mul_valid   out  1        issue strobe to the multiplier
//   mul_a       out  32       operand A to the multiplier
//   mul_b       out  32       operand B to the multiplier
//   mul_z       in   32       product, valid LAT cycles after issue
//   mul_flags   in   5        exception flags aligned with mul_z
//   rsp_valid   out  NREQ     one-hot single-cycle response strobe
//   rsp_z       out  32       product returned with rsp_valid
//   rsp_flags   out  5        flags returned with rsp_valid
//   busy        out  1        an operation is issuing, in flight or responding
// -----------------------------------------------------------------------------
module fpmult_rr_arbiter #(
   parameter int NREQ = 4,
   parameter int LAT  = 3,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ*32-1:0] req_a,
   input  logic [NREQ*32-1:0] req_b,
   output logic [NREQ-1:0]    req_ready,
   input  logic               issue_hold,
   output logic               mul_valid,
   output logic [31:0]        mul_a,
   output logic [31:0]        mul_b,
   input  logic [31:0]        mul_z,
   input  logic [4:0]         mul_flags,
   output logic [NREQ-1:0]    rsp_valid,
   output logic [31:0]        rsp_z,
   output logic [4:0]         rsp_flags,
   output logic               busy
);

   // Arbitration state and issue registers
   logic [IDW-1:0]  r_rr_ptr;
   logic            r_mul_valid;
   logic [31:0]     r_mul_a;
   logic [31:0]     r_mul_b;
   logic [IDW-1:0]  r_issue_id;

   // Tag pipeline, stage LAT-1 lines up with mul_z
   logic [LAT-1:0]  r_tag_vld;
   logic [IDW-1:0]  r_tag_id [LAT];

   // Response register
   logic [NREQ-1:0] r_rsp_valid;
   logic [31:0]     r_rsp_z;

   // Arbiter outputs
   logic [NREQ-1:0] w_grant;
   logic [IDW-1:0]  w_gid;
   logic            w_accept;
   logic [IDW-1:0]  w_scan_idx;
   logic [IDW-1:0]  w_next_ptr;

   // Unpacked operand views so the granted requester is a plain array index
   logic [31:0]     w_a_arr [NREQ];
   logic [31:0]     w_b_arr [NREQ];

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign w_a_arr[gi] = req_a[32*gi +: 32];
      assign w_b_arr[gi] = req_b[32*gi +: 32];
   end

   // Round-robin scan starting at r_rr_ptr; first pending requester wins.
   // NOTE: every variable gets a default before the loop so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      w_grant    = '0;
      w_gid      = '0;
      w_accept   = 1'b0;
      w_scan_idx = '0;
      if (!issue_hold) begin
         for (int off = 0; off < NREQ; off++) begin
            w_scan_idx = IDW'((int'(r_rr_ptr) + off) % NREQ);
            if (!w_accept && req_valid[w_scan_idx]) begin
               w_accept            = 1'b1;
               w_grant[w_scan_idx] = 1'b1;
               w_gid               = w_scan_idx;
            end
         end
      end
   end

   // The winner goes to the back of the queue; NREQ-1 wraps to 0.
   assign w_next_ptr = (w_gid == IDW'(NREQ - 1)) ? '0 : w_gid + 1'b1;

   // NOTE: all sequential state uses non-blocking assignments so every
   // register samples the pre-edge value of its neighbours (the tag shift
   // depends on this).
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr_ptr    <= '0;
         r_mul_valid <= 1'b0;
         r_mul_a     <= '0;
         r_mul_b     <= '0;
         r_issue_id  <= '0;
         r_tag_vld   <= '0;
         // NOTE: the id array is tiny and its reset value is observable
         // through busy-adjacent debug, so it is cleared explicitly; only
         // the valid bits are functionally required.
         for (int i = 0; i < LAT; i++) r_tag_id[i] <= '0;
         r_rsp_valid <= '0;
         r_rsp_z     <= '0;
      end else begin
         // Issue stage: operands hold when nothing is accepted
         r_mul_valid <= w_accept;
         if (w_accept) begin
            r_mul_a    <= w_a_arr[w_gid];
            r_mul_b    <= w_b_arr[w_gid];
            r_issue_id <= w_gid;
            r_rr_ptr   <= w_next_ptr;
         end

         // Tag pipeline never stalls; it mirrors the multiplier latency
         for (int i = LAT - 1; i > 0; i--) begin
            r_tag_vld[i] <= r_tag_vld[i-1];
            r_tag_id[i]  <= r_tag_id[i-1];
         end
         r_tag_vld[0] <= r_mul_valid;
         r_tag_id[0]  <= r_issue_id;

         // Response: product captured only when a tracked op completes, so a
         // product belonging to an op dropped by reset is never captured
         r_rsp_valid <= r_tag_vld[LAT-1] ? (NREQ'(1) << r_tag_id[LAT-1]) : '0;
         if (r_tag_vld[LAT-1]) r_rsp_z <= mul_z;
      end
   end

`ifdef FPMULT_ARB_FLAGS_EN
   logic [4:0] r_rsp_flags;

   always_ff @(posedge clk) begin
      if (rst)                   r_rsp_flags <= '0;
      else if (r_tag_vld[LAT-1]) r_rsp_flags <= mul_flags;
   end

   assign rsp_flags = r_rsp_flags;
`else
   // Flags are not carried in this build; the input is intentionally ignored.
   logic w_unused_flags;
   assign w_unused_flags = ^mul_flags;
   assign rsp_flags      = 5'b0;
`endif

   assign req_ready = w_grant;
   assign mul_valid = r_mul_valid;
   assign mul_a     = r_mul_a;
   assign mul_b     = r_mul_b;
   assign rsp_valid = r_rsp_valid;
   assign rsp_z     = r_rsp_z;
   assign busy      = r_mul_valid | (|r_tag_vld) | (|r_rsp_valid);

endmodule

// File: tb/tb_fpmult_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fpmult_rr_arbiter
//
// Directed bench for fpmult_rr_arbiter (NREQ=4, LAT=3). A behavioural
// fixed-latency FP32 multiplier closes the loop: it samples mul_valid/mul_a/
// mul_b on each rising edge and presents a product LAT edges later. Inputs are
// driven right after each falling edge and outputs are checked 1 time unit
// later, half a cycle away from the rising edge.
// -----------------------------------------------------------------------------
module tb_fpmult_rr_arbiter;

   localparam int NREQ = 4;
   localparam int LAT  = 3;

   logic               clk = 1'b0;
   logic               rst;
   logic [NREQ-1:0]    req_valid;
   logic [NREQ*32-1:0] req_a;
   logic [NREQ*32-1:0] req_b;
   logic [NREQ-1:0]    req_ready;
   logic               issue_hold;
   logic               mul_valid;
   logic [31:0]        mul_a;
   logic [31:0]        mul_b;
   logic [31:0]        mul_z;
   logic [4:0]         mul_flags;
   logic [NREQ-1:0]    rsp_valid;
   logic [31:0]        rsp_z;
   logic [4:0]         rsp_flags;
   logic               busy;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   fpmult_rr_arbiter #(.NREQ(NREQ), .LAT(LAT), .IDW(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_ready  (req_ready),
      .issue_hold (issue_hold),
      .mul_valid  (mul_valid),
      .mul_a      (mul_a),
      .mul_b      (mul_b),
      .mul_z      (mul_z),
      .mul_flags  (mul_flags),
      .rsp_valid  (rsp_valid),
      .rsp_z      (rsp_z),
      .rsp_flags  (rsp_flags),
      .busy       (busy)
   );

   // ---------------- multiplier model ----------------
   // Truncating normal-number FP32 multiply; inf*0 gives a quiet NaN with the
   // invalid flag (bit 4). Adequate for the exact products used here.
   function automatic logic [36:0] fmul(input logic [31:0] a, input logic [31:0] b);
      logic        s;
      logic [7:0]  ea, eb;
      logic [47:0] p;
      int          e;
      logic [22:0] m;
      s  = a[31] ^ b[31];
      ea = a[30:23];
      eb = b[30:23];
      if ((ea == 8'hFF && eb == 8'h00) || (ea == 8'h00 && eb == 8'hFF))
         return {5'b10000, 32'h7FC00000};
      if (ea == 8'h00 || eb == 8'h00)
         return {5'b00000, s, 31'h0};
      p = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
      if (p[47]) begin
         m = p[46:24];
         e = int'(ea) + int'(eb) - 126;
      end else begin
         m = p[45:23];
         e = int'(ea) + int'(eb) - 127;
      end
      return {5'b00000, s, e[7:0], m};
   endfunction

   logic [31:0] m_z [LAT];
   logic [4:0]  m_f [LAT];
   logic [36:0] m_res;

   assign m_res = fmul(mul_a, mul_b);

   always @(posedge clk) begin
      m_z[0] <= m_res[31:0];
      m_f[0] <= m_res[36:32];
      for (int i = 1; i < LAT; i++) begin
         m_z[i] <= m_z[i-1];
         m_f[i] <= m_f[i-1];
      end
   end

   assign mul_z     = m_z[LAT-1];
   assign mul_flags = m_f[LAT-1];

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(negedge clk);
   endtask

   // Hand-computed products for each requester's standing operands
   logic [31:0] prod [NREQ] = '{32'h40800000, 32'h40100000, 32'h40400000, 32'h40C00000};

   // Responses expected during the 13-cycle burst window
   logic [3:0] burst_rsp [13] = '{4'b0000, 4'b1000, 4'b0001, 4'b1000, 4'b0000,
                                  4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                  4'b0001, 4'b0010, 4'b0100, 4'b1000};

   // ---------------- stimulus ----------------
   initial begin
      rst        = 1'b1;
      issue_hold = 1'b0;
      req_valid  = '0;
      req_a[ 31: 0] = 32'h40000000;  req_b[ 31: 0] = 32'h40000000;  // 2.0*2.0
      req_a[ 63:32] = 32'h3FC00000;  req_b[ 63:32] = 32'h3FC00000;  // 1.5*1.5
      req_a[ 95:64] = 32'h3FC00000;  req_b[ 95:64] = 32'h40000000;  // 1.5*2.0
      req_a[127:96] = 32'h40400000;  req_b[127:96] = 32'h40000000;  // 3.0*2.0
      repeat (2) nxt();

      // Reset state, then a single request from requester 2
      rst = 1'b0;
      req_valid = 4'b0100;
      #1;
      chk("rst_mul_valid", 32'(mul_valid), 32'h0);
      chk("rst_mul_a",     mul_a,          32'h0);
      chk("rst_mul_b",     mul_b,          32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_rsp_z",     rsp_z,          32'h0);
      chk("rst_rsp_flags", 32'(rsp_flags), 32'h0);
      chk("rst_busy",      32'(busy),      32'h0);
      chk("single_ready",  32'(req_ready), 32'h4);

      nxt(); req_valid = '0; #1;
      chk("single_mul_valid", 32'(mul_valid), 32'h1);
      chk("single_mul_a",     mul_a,          32'h3FC00000);
      chk("single_mul_b",     mul_b,          32'h40000000);
      chk("single_ready_off", 32'(req_ready), 32'h0);
      for (int i = 0; i < 3; i++) begin
         nxt(); #1;
         chk("single_rsp_early", 32'(rsp_valid), 32'h0);
         chk("single_busy",      32'(busy),      32'h1);
      end
      nxt(); #1;
      chk("single_rsp_valid", 32'(rsp_valid), 32'h4);
      chk("single_rsp_z",     rsp_z,          32'h40400000);

      // rr_ptr is now 3: wrap test with requesters 3 and 0
      nxt(); req_valid = 4'b1001; #1;
      chk("single_rsp_done", 32'(rsp_valid), 32'h0);
      chk("single_busy_off", 32'(busy),      32'h0);
      chk("wrap_grant3",     32'(req_ready), 32'h8);
      nxt(); #1;
      chk("wrap_grant0",  32'(req_ready), 32'h1);
      chk("wrap_mul_a3",  mul_a,          32'h40400000);
      nxt(); req_valid = 4'b1000; #1;
      chk("wrap_only3",   32'(req_ready), 32'h8);
      chk("wrap_mul_a0",  mul_a,          32'h40000000);
      nxt(); req_valid = '0; #1;
      chk("wrap_idle",    32'(req_ready), 32'h0);
      chk("wrap_mul_a3b", mul_a,          32'h40400000);

      // All four requesting for 8 cycles; wrap responses overlap the burst
      for (int i = 0; i < 13; i++) begin
         nxt();
         req_valid = (i < 8) ? 4'b1111 : 4'b0000;
         #1;
         chk("burst_ready",     32'(req_ready), (i < 8) ? (32'h1 << (i % 4)) : 32'h0);
         chk("burst_mul_valid", 32'(mul_valid), (i >= 1 && i <= 8) ? 32'h1 : 32'h0);
         chk("burst_rsp_valid", 32'(rsp_valid), 32'(burst_rsp[i]));
         for (int r = 0; r < NREQ; r++)
            if (burst_rsp[i][r]) chk("burst_rsp_z", rsp_z, prod[r]);
      end

      // issue_hold with two ops in flight
      nxt(); req_valid = 4'b0011; #1;
      chk("burst_busy_off", 32'(busy),      32'h0);
      chk("hold_grant0",    32'(req_ready), 32'h1);
      nxt(); #1;
      chk("hold_grant1",    32'(req_ready), 32'h2);
      nxt(); issue_hold = 1'b1; #1;
      chk("hold_ready_off", 32'(req_ready), 32'h0);
      chk("hold_last_issue", 32'(mul_valid), 32'h1);
      for (int i = 0; i < 4; i++) begin
         nxt(); #1;
         chk("hold_ready",     32'(req_ready), 32'h0);
         chk("hold_mul_valid", 32'(mul_valid), 32'h0);
         chk("hold_busy",      32'(busy),      32'h1);
         chk("hold_rsp_valid", 32'(rsp_valid), (i == 2) ? 32'h1 : (i == 3) ? 32'h2 : 32'h0);
         if (i == 2) chk("hold_rsp_z0", rsp_z, prod[0]);
         if (i == 3) chk("hold_rsp_z1", rsp_z, prod[1]);
      end
      nxt(); #1;
      chk("hold_busy_off",  32'(busy),      32'h0);
      chk("hold_rsp_off",   32'(rsp_valid), 32'h0);

      // Reset one cycle after an issue drops the op
      nxt(); issue_hold = 1'b0; req_valid = 4'b0100; #1;
      chk("rstop_grant2",   32'(req_ready), 32'h4);
      nxt(); req_valid = '0; #1;
      chk("rstop_issue",    32'(mul_valid), 32'h1);
      rst = 1'b1;
      nxt(); rst = 1'b0; #1;
      chk("rstop_mul_valid", 32'(mul_valid), 32'h0);
      chk("rstop_mul_a",     mul_a,          32'h0);
      chk("rstop_mul_b",     mul_b,          32'h0);
      chk("rstop_rsp_z",     rsp_z,          32'h0);
      chk("rstop_ready",     32'(req_ready), 32'h0);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) begin nxt(); #1; end
         chk("rstop_rsp_valid", 32'(rsp_valid), 32'h0);
         chk("rstop_busy",      32'(busy),      32'h0);
      end

      // rr_ptr back at 0; inf*0 from requester 0 exercises the flags path
      nxt();
      req_a[31:0] = 32'h7F800000;
      req_b[31:0] = 32'h00000000;
      req_valid   = 4'b1111;
      #1;
      chk("flag_ptr_reset", 32'(req_ready), 32'h1);
      nxt(); req_valid = '0; #1;
      chk("flag_mul_a",     mul_a, 32'h7F800000);
      repeat (4) nxt();
      #1;
      chk("flag_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("flag_rsp_z",     rsp_z,          32'h7FC00000);
`ifdef FPMULT_ARB_FLAGS_EN
      chk("flag_rsp_flags", 32'(rsp_flags), 32'h10);
`else
      chk("flag_rsp_flags_tied", 32'(rsp_flags), 32'h0);
`endif
      nxt(); #1;
      chk("flag_rsp_off",   32'(rsp_valid), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
